// File: rtl/lookahead_hash_buffer.sv
// Lookahead window between the input FIFO and the match stage: collects up to LA_LEN bytes,
// presents them with a 3-byte hash, and drains the tail on flush.
module lookahead_hash_buffer #(
    parameter int unsigned LA_LEN    = 4,
    parameter int unsigned HASH_BITS = 12
) (
    input  logic                         ClkxCI,
    input  logic                         RstxRI,
    input  logic [7:0]                   DInxDI,
    input  logic                         StrobexSI,
    input  logic                         FlushxSI,
    output logic                         StopInxSO,
    output logic [8*LA_LEN-1:0]          WinxDO,
    output logic [$clog2(LA_LEN+1)-1:0]  WinLenxDO,
    output logic [HASH_BITS-1:0]         HashxDO,
    output logic                         OutValidxSO,
    input  logic                         OutReadyxSI,
    output logic                         DonexSO,
    output logic                         OverflowxSO
);

    localparam int unsigned LEN_W = $clog2(LA_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(LA_LEN);
    localparam logic [LEN_W-1:0] LEN_STOP = LEN_W'(LA_LEN - 1);
    localparam logic [31:0] HASH_MULT = 32'd40543;

    localparam logic [1:0] StFill  = 2'd0;
    localparam logic [1:0] StFull  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [LA_LEN-1:0][7:0]  win_q, win_d;
    logic [LEN_W-1:0]        win_len_q, win_len_d;
    logic                    stop_q, stop_d;
    logic                    ovf_q, ovf_d;

    logic                    out_valid;
    logic                    consume;
    logic                    accept;
    logic [15:0]             hash_key;
    logic [31:0]             hash_prod;

    always_comb begin
        out_valid = (state_q == StFull) || ((state_q == StDrain) && (win_len_q != '0));
        consume   = out_valid && OutReadyxSI;
        accept    = StrobexSI && ((state_q == StFill) || (state_q == StFull));
    end

    // Window update: consume shifts first, so a simultaneous strobe lands at the new top slot.
    always_comb begin
        win_d     = win_q;
        win_len_d = win_len_q;
        ovf_d     = ovf_q;

        if (consume) begin
            for (int i = 0; i < int'(LA_LEN) - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[LA_LEN-1] = 8'h00;
            win_len_d       = win_len_q - LEN_W'(1);
        end

        if (accept) begin
            if (win_len_d < LEN_FULL) begin
                for (int i = 0; i < int'(LA_LEN); i++) begin
                    if (win_len_d == LEN_W'(i)) begin
                        win_d[i] = DInxDI;
                    end
                end
                win_len_d = win_len_d + LEN_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFill, StFull: begin
                if (FlushxSI) begin
                    state_d = StDrain;
                end else if (win_len_d == LEN_FULL) begin
                    state_d = StFull;
                end else begin
                    state_d = StFill;
                end
            end
            StDrain: begin
                if (win_len_q == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StDone;
        endcase
    end

    // One byte of slack: the FIFO may still deliver a byte after StopIn rises.
    always_comb begin
        stop_d = (state_d == StDone) || (win_len_d >= LEN_STOP);
    end

    always_ff @(posedge ClkxCI or negedge RstxRI) begin
        if (!RstxRI) begin
            state_q   <= StFill;
            win_q     <= '0;
            win_len_q <= '0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            win_len_q <= win_len_d;
            stop_q    <= stop_d;
            ovf_q     <= ovf_d;
        end
    end

    // Empty slots are held at zero, so the hash needs no masking of invalid bytes.
    always_comb begin
        hash_key  = {win_q[0], 8'h00} ^ {4'h0, win_q[1], 4'h0} ^ {8'h00, win_q[2]};
        hash_prod = 32'(hash_key) * HASH_MULT;
        HashxDO   = HASH_BITS'(hash_prod >> 4);
    end

    always_comb begin
        WinxDO      = win_q;
        WinLenxDO   = win_len_q;
        StopInxSO   = stop_q;
        OutValidxSO = out_valid;
        DonexSO     = (state_q == StDone);
        OverflowxSO = ovf_q;
    end

endmodule

// File: tb/tb_lookahead_hash_buffer.sv
// Directed bench for lookahead_hash_buffer at default parameters (LA_LEN=4, HASH_BITS=12).
module tb_lookahead_hash_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        strobe;
    logic        flush;
    logic        ready;
    logic        stop;
    logic [31:0] win;
    logic [2:0]  win_len;
    logic [11:0] hash;
    logic        valid;
    logic        done;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lookahead_hash_buffer #(
        .LA_LEN    (4),
        .HASH_BITS (12)
    ) dut (
        .ClkxCI      (clk),
        .RstxRI      (rst_n),
        .DInxDI      (din),
        .StrobexSI   (strobe),
        .FlushxSI    (flush),
        .StopInxSO   (stop),
        .WinxDO      (win),
        .WinLenxDO   (win_len),
        .HashxDO     (hash),
        .OutValidxSO (valid),
        .OutReadyxSI (ready),
        .DonexSO     (done),
        .OverflowxSO (ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        strobe = 1'b0;
        flush  = 1'b0;
        ready  = 1'b0;
        din    = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (win_len !== 3'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", win_len); end
        checks++; if (win !== 32'h0) begin errors++; $display("FAIL reset_win: got %h want 0", win); end
        checks++; if (hash !== 12'h000) begin errors++; $display("FAIL reset_hash: got %h want 000", hash); end
        checks++; if ({stop, valid, done, ovf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {stop, valid, done, ovf});
        end
    endtask

    task automatic test_fill;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            din = 8'h61 + 8'(i);
            strobe = 1'b1;
            tick();
            checks++; if (win_len !== 3'(i + 1)) begin
                errors++; $display("FAIL fill_len[%0d]: got %0d want %0d", i, win_len, i + 1);
            end
            checks++; if (stop !== (i >= 2)) begin
                errors++; $display("FAIL fill_stop[%0d]: got %b want %b", i, stop, i >= 2);
            end
            checks++; if (valid !== (i == 3)) begin
                errors++; $display("FAIL fill_valid[%0d]: got %b want %b", i, valid, i == 3);
            end
        end
        strobe = 1'b0;
        tick();
        checks++; if (win !== 32'h64636261) begin errors++; $display("FAIL fill_win: got %h want 64636261", win); end
        checks++; if (hash !== 12'hABD) begin errors++; $display("FAIL fill_hash: got %h want abd", hash); end
        checks++; if (win_len !== 3'd4 || valid !== 1'b1 || stop !== 1'b1) begin
            errors++; $display("FAIL fill_hold: got len=%0d v=%b s=%b want 4 1 1", win_len, valid, stop);
        end
    endtask

    task automatic test_back_to_back;
        ready = 1'b1;
        strobe = 1'b1;
        din = 8'h65;
        tick();
        ready = 1'b0;
        strobe = 1'b0;
        checks++; if (win !== 32'h65646362) begin errors++; $display("FAIL b2b_win: got %h want 65646362", win); end
        checks++; if (win_len !== 3'd4) begin errors++; $display("FAIL b2b_len: got %0d want 4", win_len); end
        checks++; if (hash !== 12'h132) begin errors++; $display("FAIL b2b_hash: got %h want 132", hash); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overflow;
        strobe = 1'b1;
        din = 8'h99;
        tick();
        strobe = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        checks++; if (win !== 32'h65646362) begin errors++; $display("FAIL ovf_win: got %h want 65646362", win); end
        checks++; if (win_len !== 3'd4) begin errors++; $display("FAIL ovf_len: got %0d want 4", win_len); end
        tick();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_drain;
        int valid_cycles;
        int n;
        apply_reset();
        strobe = 1'b1;
        din = 8'h11;
        tick();
        din = 8'h22;
        tick();
        strobe = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drain_prefill_valid: got %b want 0", valid); end
        flush = 1'b1;
        ready = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (win_len !== 3'd2) begin errors++; $display("FAIL drain_len2: got %0d want 2", win_len); end
        checks++; if (win !== 32'h00002211) begin errors++; $display("FAIL drain_win2: got %h want 00002211", win); end
        valid_cycles = 0;
        if (valid) valid_cycles++;
        tick();
        if (valid) valid_cycles++;
        checks++; if (win_len !== 3'd1) begin errors++; $display("FAIL drain_len1: got %0d want 1", win_len); end
        checks++; if (win !== 32'h00000022) begin errors++; $display("FAIL drain_win1: got %h want 00000022", win); end
        tick();
        if (valid) valid_cycles++;
        checks++; if (win_len !== 3'd0) begin errors++; $display("FAIL drain_len0: got %0d want 0", win_len); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain_early_done: got %b want 0", done); end
        n = 0;
        while (!done && n < 8) begin
            tick();
            if (valid) valid_cycles++;
            n++;
        end
        checks++; if (valid_cycles != 2) begin
            errors++; $display("FAIL drain_valid_cycles: got %0d want 2", valid_cycles);
        end
        checks++; if (done !== 1'b1 || stop !== 1'b1) begin
            errors++; $display("FAIL drain_done: got done=%b stop=%b want 1 1", done, stop);
        end
        ready = 1'b0;
        strobe = 1'b1;
        din = 8'h77;
        tick();
        strobe = 1'b0;
        checks++; if (ovf !== 1'b0 || win_len !== 3'd0 || done !== 1'b1) begin
            errors++; $display("FAIL done_ignore: got ovf=%b len=%0d done=%b want 0 0 1", ovf, win_len, done);
        end
    endtask

    task automatic test_flush_with_strobe;
        apply_reset();
        din = 8'h41;
        strobe = 1'b1;
        flush = 1'b1;
        tick();
        strobe = 1'b0;
        flush = 1'b0;
        checks++; if (win_len !== 3'd1 || win !== 32'h00000041) begin
            errors++; $display("FAIL flush_strobe_win: got len=%0d win=%h want 1 00000041", win_len, win);
        end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL flush_strobe_valid: got %b want 1", valid); end
    endtask

    task automatic test_reset_mid_drain;
        apply_reset();
        strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'h31 + 8'(i);
            tick();
        end
        strobe = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (valid !== 1'b1 || win_len !== 3'd3 || stop !== 1'b1) begin
            errors++; $display("FAIL mid_drain_pre: got v=%b len=%0d s=%b want 1 3 1", valid, win_len, stop);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (win !== 32'h0 || win_len !== 3'd0 || hash !== 12'h000) begin
            errors++; $display("FAIL async_rst_data: got win=%h len=%0d hash=%h want 0 0 0", win, win_len, hash);
        end
        checks++; if ({stop, valid, done, ovf} !== 4'b0000) begin
            errors++; $display("FAIL async_rst_flags: got %b want 0000", {stop, valid, done, ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h61 + 8'(i);
            tick();
        end
        strobe = 1'b0;
        checks++; if (win_len !== 3'd4 || valid !== 1'b1) begin
            errors++; $display("FAIL refill_state: got len=%0d v=%b want 4 1", win_len, valid);
        end
        checks++; if (win !== 32'h64636261 || hash !== 12'hABD) begin
            errors++; $display("FAIL refill_data: got win=%h hash=%h want 64636261 abd", win, hash);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        din    = 8'h00;
        strobe = 1'b0;
        flush  = 1'b0;
        ready  = 1'b0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_overflow();
        test_drain();
        test_flush_with_strobe();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lookahead_hash_buffer.md
LOOKAHEAD_HASH_BUFFER -- requirements
Module: lookahead_hash_buffer

Interface
REQ-001 The block SHALL have parameter LA_LEN, default 4, giving the lookahead window depth in bytes; legal values are 3..16.
REQ-002 The block SHALL have parameter HASH_BITS, default 12, giving the hash output width; legal values are 8..12.
REQ-003 The block SHALL have port ClkxCI, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RstxRI, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port DInxDI, input, 8 bits: the byte from the input FIFO.
REQ-006 The block SHALL have port StrobexSI, input, 1 bit: DInxDI is valid this cycle (driven by the FIFO OutStrobe).
REQ-007 The block SHALL have port FlushxSI, input, 1 bit: end-of-stream pulse that starts draining.
REQ-008 The block SHALL have port StopInxSO, output, 1 bit, registered: drives the FIFO StopOutput.
REQ-009 The block SHALL have port WinxDO, output, 8*LA_LEN bits: the window, with byte 0 (oldest) in bits [7:0].
REQ-010 The block SHALL have port WinLenxDO, output, clog2(LA_LEN+1) bits: the number of valid window bytes.
REQ-011 The block SHALL have port HashxDO, output, HASH_BITS bits: the hash of window bytes 0..2.
REQ-012 The block SHALL have port OutValidxSO, output, 1 bit: the window is presented to the downstream stage.
REQ-013 The block SHALL have port OutReadyxSI, input, 1 bit: the downstream stage consumes window byte 0.
REQ-014 The block SHALL have port DonexSO, output, 1 bit: the drain is complete.
REQ-015 The block SHALL have port OverflowxSO, output, 1 bit: sticky flag for a dropped byte.

Function
REQ-016 The block SHALL implement the states FILL, FULL, DRAIN and DONE; the reset state SHALL be FILL.
REQ-017 In FILL, each strobe SHALL write DInxDI at position WinLen and increment WinLen; reaching LA_LEN SHALL move the state to FULL.
REQ-018 OutValidxSO SHALL be 1 in FULL, 1 in DRAIN while WinLen>0, and 0 otherwise.
REQ-019 A consume (OutValidxSO=1 and OutReadyxSI=1) SHALL shift the window down by one byte, zero the top vacated position, and decrement WinLen.
REQ-020 A consume and a strobe in the same cycle SHALL shift the window and write the new byte at the new position WinLen-1, leaving WinLen unchanged.
REQ-021 In FULL, a consume without a strobe SHALL return the state to FILL.
REQ-022 StopInxSO SHALL be registered and equal to 1 when the next WinLen is >= LA_LEN-1, giving one byte of slack for FIFO stop latency.
REQ-023 A strobe with WinLen=LA_LEN and no consume SHALL drop the byte and set OverflowxSO until reset.
REQ-024 FlushxSI in FILL or FULL SHALL move the state to DRAIN; strobes in DRAIN or DONE SHALL be ignored and SHALL NOT set the overflow flag.
REQ-025 DRAIN with WinLen=0 SHALL move the state to DONE; in DONE, DonexSO=1 and StopInxSO=1 until reset.
REQ-026 A FlushxSI coincident with a strobe SHALL accept the byte first, then enter DRAIN.
REQ-027 The hash SHALL be a combinational function of the registered window only: key = (b0<<8) XOR (b1<<4) XOR b2 (16 bits); HashxDO = bits [HASH_BITS+3:4] of the 32-bit product key*40543.
REQ-028 Invalid window positions SHALL read as 0x00 in both WinxDO and the hash.

Reset
REQ-029 Assertion of RstxRI=0 SHALL immediately clear the window, WinLenxDO, StopInxSO, OutValidxSO, DonexSO and OverflowxSO, which forces HashxDO to 0x000; the state SHALL become FILL.
REQ-030 A reset asserted mid-DRAIN SHALL discard all bytes; after release the block SHALL accept a new stream in FILL.

Verification
REQ-031 The bench SHALL check: 4 strobes 0x61,0x62,0x63,0x64 with OutReadyxSI=0 -> OutValidxSO=1, WinLenxDO=4, HashxDO=0xABD, StopInxSO=1 from the cycle after the 3rd byte.
REQ-032 The bench SHALL check: full window plus OutReadyxSI=1 and strobe 0x65 in the same cycle -> WinxDO bytes 0x62,0x63,0x64,0x65, WinLenxDO stays 4.
REQ-033 The bench SHALL check: full window, OutReadyxSI=0, 5th strobe -> byte dropped, OverflowxSO=1, WinxDO unchanged.
REQ-034 The bench SHALL check: 2 bytes, then FlushxSI, then OutReadyxSI=1 -> OutValidxSO=1 for 2 cycles, WinLenxDO 2->1->0, then DonexSO=1.
REQ-035 The bench SHALL check: RstxRI=0 pulsed asynchronously mid-DRAIN -> all outputs 0 before the next clock edge, then a new stream fills correctly.
